cajero_multi: RTL

Parametrised ATM session controller, successor of the single-transaction teller FSM.
- Takes a card, collects a PIN of configurable length, and allows a configurable number of failed attempts before a sticky lockout.
- Runs any number of deposit/withdraw transactions per session against a balance latched at card acceptance.
- Adds a per-session withdrawal cap and an inactivity timeout.
- Sits between the card/keypad front end and the account back end.

---
 rtl/cajero_pkg.sv | 23 ++
 rtl/cajero_temporizador.sv | 31 +++
 rtl/cajero_multi.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cajero_pkg.sv
// Shared types and constants for the ATM session controller.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package cajero_pkg;

    localparam int DIGITO_W = 4;

    typedef enum logic [2:0] {
        ESPERA,
        PIN,
        VERIFICA,
        MENU,
        DEPOSITO,
        RETIRO,
        BLOQUEADO
    } estado_t;

    // States in which an idle user can be timed out
    function automatic logic es_temporizado(input estado_t e);
        return (e == PIN) || (e == MENU) || (e == DEPOSITO) || (e == RETIRO);
    endfunction

endpackage

// File: rtl/cajero_temporizador.sv
// Idle counter: counts enabled, non-cleared cycles and flags the last one.
// Latency: expira is combinational on the cycle the count sits at TIMEOUT_CICLOS-1.
// Backpressure: none; limpiar wins over expiry, disabling also zeroes the count.
module cajero_temporizador #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic limpiar,
    input  logic habilitar,
    output logic expira
);

    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(TIMEOUT_CICLOS - 1);

    logic [CW-1:0] cuenta;

    // A pending strobe suppresses expiry so user input is never lost to the timer
    assign expira = habilitar && !limpiar && (cuenta == ULTIMO);

    // Count idle cycles; restart on activity, when not timing, and after firing
    always_ff @(posedge CLK) begin
        if (!RESET || limpiar || !habilitar || expira) begin
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/cajero_multi.sv
// ATM session controller: card, PIN with lockout, repeated deposits/withdrawals, cap, idle abort.
// Latency: every result pulse and balance update is registered, visible the cycle after its strobe.
// Backpressure: none; strobes not consumed by the current state are dropped.
module cajero_multi
    import cajero_pkg::*;
#(
    parameter int              PIN_DIGITS     = 4,
    parameter int              MAX_INTENTOS   = 3,
    parameter int              BAL_W          = 64,
    parameter int              MONTO_W        = 32,
    parameter longint unsigned LIMITE_RETIRO  = 100000,
    parameter int              TIMEOUT_CICLOS = 1000
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           TARJETA_RECIBIDA,
    input  logic [DIGITO_W*PIN_DIGITS-1:0] PIN_CORRECTO,
    input  logic [DIGITO_W-1:0]            DIGITO,
    input  logic                           DIGITO_STB,
    input  logic                           TIPO_TRANS,
    input  logic                           TRANS_STB,
    input  logic [MONTO_W-1:0]             MONTO,
    input  logic                           MONTO_STB,
    input  logic                           FIN_SESION,
    input  logic [BAL_W-1:0]               BALANCE_INICIAL,
    output logic [BAL_W-1:0]               BALANCE_ACTUALIZADO,
    output logic                           BALANCE_STB,
    output logic                           ENTREGAR_DINERO,
    output logic                           FONDOS_INSUFICIENTES,
    output logic                           LIMITE_EXCEDIDO,
    output logic                           PIN_INCORRECTO,
    output logic                           ADVERTENCIA,
    output logic                           BLOQUEO,
    output logic                           TIMEOUT,
    output logic [3:0]                     INTENTOS_RESTANTES
);

    localparam int PIN_W = DIGITO_W * PIN_DIGITS;
    localparam int CDW   = $clog2(PIN_DIGITS + 1);
    localparam logic [CDW-1:0] ULTIMO_DIG = CDW'(PIN_DIGITS - 1);
    localparam logic [3:0]     MAX_INT    = 4'(MAX_INTENTOS);

    // The session total is held in MONTO_W bits, so the effective cap is clipped
    // to what that register can represent; accepted totals then always fit.
    localparam longint unsigned MONTO_MAX = (MONTO_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                            : ((64'd1 << MONTO_W) - 64'd1);
    localparam longint unsigned LIM_EF    = (LIMITE_RETIRO < MONTO_MAX) ? LIMITE_RETIRO : MONTO_MAX;
    localparam logic [MONTO_W:0] LIMITE   = (MONTO_W + 1)'(LIM_EF);

    estado_t            estado;
    logic [PIN_W-1:0]   pin_reg;
    logic [CDW-1:0]     cont_dig;
    logic [3:0]         intentos;
    logic [MONTO_W-1:0] total;
    logic [BAL_W-1:0]   saldo;

    logic [BAL_W-1:0]   monto_ext;
    logic [MONTO_W:0]   total_prop;
    logic [3:0]         intentos_sig;
    logic               sin_fondos;
    logic               sobre_limite;
    logic               strobe_aceptado;
    logic               temporizado;
    logic               expira;

    assign monto_ext    = BAL_W'(MONTO);
    // One extra bit so the prospective total cannot wrap past the cap unnoticed
    assign total_prop   = {1'b0, total} + {1'b0, MONTO};
    assign intentos_sig = intentos + 4'd1;
    assign sin_fondos   = monto_ext > saldo;
    assign sobre_limite = total_prop > LIMITE;
    assign temporizado  = es_temporizado(estado);

    // Strobes that the current state actually consumes; these restart the idle timer
    always_comb begin
        strobe_aceptado = 1'b0;
        case (estado)
            PIN:               strobe_aceptado = DIGITO_STB;
            MENU:              strobe_aceptado = TRANS_STB || FIN_SESION;
            DEPOSITO, RETIRO:  strobe_aceptado = MONTO_STB;
            default:           strobe_aceptado = 1'b0;
        endcase
    end

    cajero_temporizador #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_temporizador (
        .CLK      (CLK),
        .RESET    (RESET),
        .limpiar  (strobe_aceptado),
        .habilitar(temporizado),
        .expira   (expira)
    );

    assign BALANCE_ACTUALIZADO = saldo;
    assign BLOQUEO             = (estado == BLOQUEADO);
    assign ADVERTENCIA         = ((estado == PIN) || (estado == VERIFICA)) && (intentos == MAX_INT - 4'd1);
    assign INTENTOS_RESTANTES  = MAX_INT - intentos;

    // Session FSM with registered one-cycle result pulses
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            estado               <= ESPERA;
            pin_reg              <= '0;
            cont_dig             <= '0;
            intentos             <= '0;
            total                <= '0;
            saldo                <= '0;
            BALANCE_STB          <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            LIMITE_EXCEDIDO      <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            TIMEOUT              <= 1'b0;
        end else begin
            BALANCE_STB          <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            LIMITE_EXCEDIDO      <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            TIMEOUT              <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (TARJETA_RECIBIDA) begin
                        saldo    <= BALANCE_INICIAL;
                        cont_dig <= '0;
                        intentos <= '0;
                        total    <= '0;
                        estado   <= PIN;
                    end
                end
                PIN: begin
                    if (DIGITO_STB) begin
                        pin_reg <= {pin_reg[PIN_W-DIGITO_W-1:0], DIGITO};
                        if (cont_dig == ULTIMO_DIG) begin
                            cont_dig <= '0;
                            estado   <= VERIFICA;
                        end else begin
                            cont_dig <= cont_dig + 1'b1;
                        end
                    end else if (expira) begin
                        TIMEOUT  <= 1'b1;
                        cont_dig <= '0;
                        estado   <= ESPERA;
                    end
                end
                VERIFICA: begin
                    if (pin_reg == PIN_CORRECTO) begin
                        intentos <= '0;
                        estado   <= MENU;
                    end else begin
                        PIN_INCORRECTO <= 1'b1;
                        intentos       <= intentos_sig;
                        estado         <= (intentos_sig == MAX_INT) ? BLOQUEADO : PIN;
                    end
                end
                MENU: begin
                    if (TRANS_STB) begin
                        estado <= TIPO_TRANS ? RETIRO : DEPOSITO;
                    end else if (FIN_SESION) begin
                        estado <= ESPERA;
                    end else if (expira) begin
                        TIMEOUT <= 1'b1;
                        estado  <= ESPERA;
                    end
                end
                DEPOSITO: begin
                    if (MONTO_STB) begin
                        saldo       <= saldo + monto_ext;
                        BALANCE_STB <= 1'b1;
                        estado      <= MENU;
                    end else if (expira) begin
                        TIMEOUT <= 1'b1;
                        estado  <= ESPERA;
                    end
                end
                RETIRO: begin
                    if (MONTO_STB) begin
                        BALANCE_STB <= 1'b1;
                        estado      <= MENU;
                        if (sin_fondos) begin
                            FONDOS_INSUFICIENTES <= 1'b1;
                        end else if (sobre_limite) begin
                            LIMITE_EXCEDIDO <= 1'b1;
                        end else begin
                            saldo           <= saldo - monto_ext;
                            total           <= total_prop[MONTO_W-1:0];
                            ENTREGAR_DINERO <= 1'b1;
                        end
                    end else if (expira) begin
                        TIMEOUT <= 1'b1;
                        estado  <= ESPERA;
                    end
                end
                BLOQUEADO: begin
                    estado <= BLOQUEADO;
                end
                default: begin
                    estado <= ESPERA;
                end
            endcase
        end
    end

endmodule
